enable_table_loader: RTL

ENABLE_TABLE_LOADER -- requirements
Module: enable_table_loader

---
 rtl/enable_table_loader_if.sv | 33 +++
 rtl/enable_table_loader.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/enable_table_loader_if.sv
// Enable-table loader bus: byte stream in (start/valid/ready), table writes
// and status out. The loader side uses the slave modport; whatever feeds it
// and consumes the table writes uses the master modport.
//
// Handshake: a byte moves from producer to loader on a rising edge where
// in_valid and in_ready are both 1. The producer may raise in_valid at any
// time and must hold in_data stable while in_valid is high and in_ready is
// low; in_ready never depends on in_valid, and in_data is ignored whenever
// in_ready is 0.
interface enable_table_loader_if #(
    parameter int TABLE_ADDR_BITS = 9
);
    logic                       start;
    logic [7:0]                 in_data;
    logic                       in_valid;
    logic                       in_ready;
    logic                       table_we;
    logic [1:0]                 table_val;
    logic [TABLE_ADDR_BITS-1:0] table_write_addr;
    logic                       busy;
    logic                       done;
    logic                       error;

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, table_we, table_val, table_write_addr, busy, done, error
    );

    modport master (
        output start, in_data, in_valid,
        input  in_ready, table_we, table_val, table_write_addr, busy, done, error
    );
endinterface

// File: rtl/enable_table_loader.sv
// Enable-table loader: accepts packed bytes (four 2-bit entries each, LSB pair
// first) and writes them to consecutive enable-table addresses, one entry per
// cycle, until the last address has been written.
//
// Optional feature: define ENABLE_TABLE_CHECKSUM_EN to add an 8-bit running
// checksum over the data bytes and a trailing check byte that must equal the
// two's complement of that sum; a mismatch sets the sticky error flag. Without
// the macro the error output is constant 0 and no check byte is expected.
//
// state_o exposes the FSM state for observation (0 IDLE, 1 FETCH, 2 UNPACK,
// 3 CHECK, 4 FINISH).
module enable_table_loader #(
    parameter int TABLE_ADDR_BITS = 9
) (
    input  logic                 fpga_clk,
    input  logic                 rst_n,
    enable_table_loader_if.slave bus,
    output logic [2:0]           state_o
);

    localparam logic [TABLE_ADDR_BITS-1:0] LAST_ADDR = '1;
    localparam logic [TABLE_ADDR_BITS-1:0] ADDR_ONE  = TABLE_ADDR_BITS'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_UNPACK = 3'd2,
`ifdef ENABLE_TABLE_CHECKSUM_EN
        ST_CHECK  = 3'd3,
`endif
        ST_FINISH = 3'd4
    } state_t;

    state_t                     state_q, state_d;
    logic [7:0]                 byte_q, byte_d;       // byte being unpacked
    logic [1:0]                 sub_q, sub_d;         // index of entry currently on the table port
    logic [TABLE_ADDR_BITS-1:0] cnt_q, cnt_d;         // address counter
    logic                       we_q, we_d;
    logic [1:0]                 val_q, val_d;
    logic [TABLE_ADDR_BITS-1:0] waddr_q, waddr_d;
    logic                       xfer;
    logic [1:0]                 next_slice;
`ifdef ENABLE_TABLE_CHECKSUM_EN
    logic [7:0]                 csum_q, csum_d;
    logic                       err_q, err_d;
`endif

    // Ready only in states that consume a byte; never a function of in_valid.
    always_comb begin
        bus.in_ready = (state_q == ST_FETCH);
`ifdef ENABLE_TABLE_CHECKSUM_EN
        if (state_q == ST_CHECK) bus.in_ready = 1'b1;
`endif
    end

    assign xfer = bus.in_valid & bus.in_ready;

    // Entry that follows the one currently presented within the latched byte.
    always_comb begin
        next_slice = byte_q[7:6];
        case (sub_q)
            2'd0:    next_slice = byte_q[3:2];
            2'd1:    next_slice = byte_q[5:4];
            default: next_slice = byte_q[7:6];
        endcase
    end

    // Next-state logic; table port registers are loaded with the write that
    // will be presented in the following cycle, so they hold when idle.
    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        sub_d   = sub_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        val_d   = val_q;
        waddr_d = waddr_q;
`ifdef ENABLE_TABLE_CHECKSUM_EN
        csum_d  = csum_q;
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_FETCH;
                    cnt_d   = '0;
                    sub_d   = 2'd0;
`ifdef ENABLE_TABLE_CHECKSUM_EN
                    csum_d  = 8'd0;
                    err_d   = 1'b0;
`endif
                end
            end
            ST_FETCH: begin
                if (xfer) begin
                    state_d = ST_UNPACK;
                    byte_d  = bus.in_data;
                    sub_d   = 2'd0;
                    we_d    = 1'b1;
                    val_d   = bus.in_data[1:0];
                    waddr_d = cnt_q;
`ifdef ENABLE_TABLE_CHECKSUM_EN
                    csum_d  = csum_q + bus.in_data;
`endif
                end
            end
            ST_UNPACK: begin
                if (sub_q != 2'd3) begin
                    sub_d   = sub_q + 2'd1;
                    cnt_d   = cnt_q + ADDR_ONE;
                    we_d    = 1'b1;
                    val_d   = next_slice;
                    waddr_d = cnt_q + ADDR_ONE;
                end else if (cnt_q == LAST_ADDR) begin
                    // Table full: counter is held at all-ones, no wrap.
`ifdef ENABLE_TABLE_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_FINISH;
`endif
                end else begin
                    cnt_d   = cnt_q + ADDR_ONE;
                    state_d = ST_FETCH;
                end
            end
`ifdef ENABLE_TABLE_CHECKSUM_EN
            ST_CHECK: begin
                if (xfer) begin
                    if (bus.in_data != (8'd0 - csum_q)) err_d = 1'b1;
                    state_d = ST_FINISH;
                end
            end
`endif
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            byte_q  <= 8'd0;
            sub_q   <= 2'd0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            val_q   <= 2'd0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            sub_q   <= sub_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            val_q   <= val_d;
            waddr_q <= waddr_d;
        end
    end

`ifdef ENABLE_TABLE_CHECKSUM_EN
    // Running checksum and sticky error flag.
    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= 8'd0;
            err_q  <= 1'b0;
        end else begin
            csum_q <= csum_d;
            err_q  <= err_d;
        end
    end
    assign bus.error = err_q;
`else
    assign bus.error = 1'b0;
`endif

    assign bus.table_we         = we_q;
    assign bus.table_val        = val_q;
    assign bus.table_write_addr = waddr_q;
    assign bus.done             = (state_q == ST_FINISH);
    assign bus.busy             = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    assign state_o              = state_q;

endmodule
